gci_irq_queue: RTL and testbench

- Downstream stage of the GCI IRQ arbiter; consumes its valid/number/ack interrupt stream and buffers the numbers in a FIFO toward the CPU-side interrupt controller.
- Decouples arbiter ack latency from CPU service time.
- Coalesces duplicate pending interrupt numbers and counts them.
- Drives the empty indication the arbiter currently ties off.

---
 rtl/gci_irq_queue_pkg.sv | 19 +
 rtl/gci_irq_queue_mem.sv | 33 +++
 rtl/gci_irq_queue.sv | 122 ++++++++++++
 tb/tb_gci_irq_queue.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/gci_irq_queue_pkg.sv
// rtl/gci_irq_queue_pkg.sv - shared GCI IRQ constants and helpers
package gci_irq_queue_pkg;

    // Interrupt number width used across the GCI interrupt path
    localparam int GCI_IRQ_NUM_W = 6;

    // Number reported when nothing meaningful is at the head
    localparam logic [GCI_IRQ_NUM_W-1:0] GCI_IRQ_INVALID = '0;

    // Default queue depth and its log2
    localparam int GCI_IRQ_Q_DEPTH   = 8;
    localparam int GCI_IRQ_Q_DEPTH_N = 3;

    // Eight-bit increment that sticks at 255
    function automatic logic [7:0] gci_sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/gci_irq_queue_mem.sv
// rtl/gci_irq_queue_mem.sv - queue entry storage, one write port and one async read port
module gci_irq_queue_mem
    import gci_irq_queue_pkg::*;
#(
    parameter int P_DEPTH   = GCI_IRQ_Q_DEPTH,
    parameter int P_DEPTH_N = GCI_IRQ_Q_DEPTH_N,
    parameter int P_NUM_W   = GCI_IRQ_NUM_W
) (
    input  logic                 iCLOCK,
    input  logic                 iRESET,
    input  logic                 iWR_EN,
    input  logic [P_DEPTH_N-1:0] iWR_ADDR,
    input  logic [P_NUM_W-1:0]   iWR_DATA,
    input  logic [P_DEPTH_N-1:0] iRD_ADDR,
    output logic [P_NUM_W-1:0]   oRD_DATA
);

    logic [P_NUM_W-1:0] r_mem [P_DEPTH];

    // Entries are cleared on reset so the head reads as the invalid number afterwards
    always_ff @(posedge iCLOCK or posedge iRESET) begin
        if (iRESET) begin
            for (int i = 0; i < P_DEPTH; i++) begin
                r_mem[i] <= P_NUM_W'(GCI_IRQ_INVALID);
            end
        end else if (iWR_EN) begin
            r_mem[iWR_ADDR] <= iWR_DATA;
        end
    end

    assign oRD_DATA = r_mem[iRD_ADDR];

endmodule

// File: rtl/gci_irq_queue.sv
// rtl/gci_irq_queue.sv - coalescing interrupt number FIFO between the GCI arbiter and the CPU
module gci_irq_queue
    import gci_irq_queue_pkg::*;
#(
    parameter int P_DEPTH   = GCI_IRQ_Q_DEPTH,
    parameter int P_DEPTH_N = GCI_IRQ_Q_DEPTH_N,
    parameter int P_NUM_W   = GCI_IRQ_NUM_W
) (
    input  logic                 iCLOCK,
    input  logic                 iRESET,
    input  logic                 iFLUSH,
    input  logic                 iIRQ_VALID,
    input  logic [P_NUM_W-1:0]   iIRQ_NUM,
    output logic                 oIRQ_ACK,
    output logic                 oCPU_IRQ_VALID,
    output logic [P_NUM_W-1:0]   oCPU_IRQ_NUM,
    input  logic                 iCPU_IRQ_ACK,
    output logic                 oEMPTY,
    output logic                 oFULL,
    output logic [P_DEPTH_N:0]   oCOUNT,
    output logic [7:0]           oCOALESCE_CNT
);

    localparam int                 LP_NUMS    = 1 << P_NUM_W;
    localparam logic [P_DEPTH_N:0] LP_FULL    = (P_DEPTH_N+1)'(P_DEPTH);
    localparam logic [P_DEPTH_N:0] LP_CNT_ONE = (P_DEPTH_N+1)'(1);
    localparam logic [P_DEPTH_N-1:0] LP_PTR_ONE = P_DEPTH_N'(1);

    logic [P_DEPTH_N-1:0] r_wptr;
    logic [P_DEPTH_N-1:0] r_rptr;
    logic [P_DEPTH_N:0]   r_count;
    logic [LP_NUMS-1:0]   r_pending;
    logic [7:0]           r_coal_cnt;

    logic [P_NUM_W-1:0]   w_head;
    logic                 w_empty;
    logic                 w_full;
    logic                 w_pop;
    logic                 w_hit;
    logic                 w_ack;
    logic                 w_push;
    logic                 w_coalesce;
    logic [LP_NUMS-1:0]   w_pending_nxt;

    gci_irq_queue_mem #(
        .P_DEPTH   (P_DEPTH),
        .P_DEPTH_N (P_DEPTH_N),
        .P_NUM_W   (P_NUM_W)
    ) u_mem (
        .iCLOCK   (iCLOCK),
        .iRESET   (iRESET),
        .iWR_EN   (w_push),
        .iWR_ADDR (r_wptr),
        .iWR_DATA (iIRQ_NUM),
        .iRD_ADDR (r_rptr),
        .oRD_DATA (w_head)
    );

    // Handshake decode: a pending number is only a duplicate if it is not leaving the head this cycle
    always_comb begin
        w_empty    = (r_count == '0);
        w_full     = (r_count == LP_FULL);
        w_pop      = iCPU_IRQ_ACK & ~w_empty & ~iFLUSH;
        w_hit      = iIRQ_VALID & r_pending[iIRQ_NUM] & ~(w_pop & (w_head == iIRQ_NUM));
        w_ack      = iIRQ_VALID & ~iFLUSH & ~iRESET & (w_hit | ~w_full);
        w_push     = w_ack & ~w_hit;
        w_coalesce = w_ack & w_hit;
    end

    // Pending bitmap update; the set follows the clear so a re-pushed number stays pending
    always_comb begin
        w_pending_nxt = r_pending;
        if (w_pop) begin
            w_pending_nxt[w_head] = 1'b0;
        end
        if (w_push) begin
            w_pending_nxt[iIRQ_NUM] = 1'b1;
        end
    end

    // Pointer, occupancy, bitmap and coalesce counter state; flush wins over push and pop
    always_ff @(posedge iCLOCK or posedge iRESET) begin
        if (iRESET) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_pending  <= '0;
            r_coal_cnt <= '0;
        end else if (iFLUSH) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_pending  <= '0;
            r_coal_cnt <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + LP_PTR_ONE;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + LP_PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + LP_CNT_ONE;
                2'b01:   r_count <= r_count - LP_CNT_ONE;
                default: r_count <= r_count;
            endcase
            r_pending <= w_pending_nxt;
            if (w_coalesce) begin
                r_coal_cnt <= gci_sat_inc8(r_coal_cnt);
            end
        end
    end

    assign oIRQ_ACK       = w_ack;
    assign oCPU_IRQ_VALID = ~w_empty;
    assign oCPU_IRQ_NUM   = w_head;
    assign oEMPTY         = w_empty;
    assign oFULL          = w_full;
    assign oCOUNT         = r_count;
    assign oCOALESCE_CNT  = r_coal_cnt;

endmodule

// File: tb/tb_gci_irq_queue.sv
// tb/tb_gci_irq_queue.sv - directed self-checking bench for gci_irq_queue
module tb_gci_irq_queue;

    logic       clk;
    logic       rst;
    logic       flush;
    logic       irq_valid;
    logic [5:0] irq_num;
    logic       irq_ack;
    logic       cpu_valid;
    logic [5:0] cpu_num;
    logic       cpu_ack;
    logic       empty;
    logic       full;
    logic [3:0] count;
    logic [7:0] coal;

    int n_vec = 0;
    int n_bad = 0;

    gci_irq_queue dut (
        .iCLOCK         (clk),
        .iRESET         (rst),
        .iFLUSH         (flush),
        .iIRQ_VALID     (irq_valid),
        .iIRQ_NUM       (irq_num),
        .oIRQ_ACK       (irq_ack),
        .oCPU_IRQ_VALID (cpu_valid),
        .oCPU_IRQ_NUM   (cpu_num),
        .iCPU_IRQ_ACK   (cpu_ack),
        .oEMPTY         (empty),
        .oFULL          (full),
        .oCOUNT         (count),
        .oCOALESCE_CNT  (coal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [5:0] n, input logic ca, input logic fl);
        @(negedge clk);
        irq_valid = v;
        irq_num   = n;
        cpu_ack   = ca;
        flush     = fl;
    endtask

    task automatic edge_sample;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; irq_valid = 1'b0; irq_num = 6'd0; cpu_ack = 1'b0;
        #1;
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_cpu_valid", cpu_valid, 0);
        chk("rst_cpu_num", cpu_num, 0);
        chk("rst_ack", irq_ack, 0);
        chk("rst_count", count, 0);
        chk("rst_coal", coal, 0);
        @(negedge clk);
        rst = 1'b0;

        // single push, visible one cycle later
        drive(1, 6'd3, 0, 0);
        #1 chk("first_ack", irq_ack, 1);
        chk("first_not_visible", cpu_valid, 0);
        edge_sample();
        chk("first_cpu_valid", cpu_valid, 1);
        chk("first_cpu_num", cpu_num, 3);
        chk("first_count", count, 1);
        chk("first_empty", empty, 0);
        drive(0, 6'd0, 1, 0);
        edge_sample();
        chk("first_pop_empty", empty, 1);

        // ordered push of 1..4 then drain
        for (int i = 0; i < 4; i++) begin
            drive(1, 6'(i + 1), 0, 0);
            edge_sample();
            chk("order_head_hold", cpu_num, 1);
        end
        chk("order_count4", count, 4);
        for (int i = 0; i < 4; i++) begin
            drive(0, 6'd0, 1, 0);
            #1 chk("order_head", cpu_num, i + 1);
            edge_sample();
        end
        chk("order_empty", empty, 1);
        chk("order_pending_clr", (dut.r_pending == 64'd0), 1);

        // duplicate coalescing and saturation
        drive(1, 6'd2, 0, 0);
        edge_sample();
        drive(1, 6'd2, 0, 0);
        #1 chk("dup_ack", irq_ack, 1);
        edge_sample();
        chk("dup_count", count, 1);
        chk("dup_coal", coal, 1);
        for (int i = 0; i < 300; i++) begin
            drive(1, 6'd2, 0, 0);
            edge_sample();
        end
        chk("dup_sat_coal", coal, 255);
        chk("dup_sat_count", count, 1);
        drive(0, 6'd0, 0, 1);
        edge_sample();
        chk("flush_coal", coal, 0);
        chk("flush_empty", empty, 1);

        // fill to full, refused push while popping, accepted next cycle
        for (int i = 0; i < 8; i++) begin
            drive(1, 6'(10 + i), 0, 0);
            edge_sample();
        end
        chk("fill_full", full, 1);
        chk("fill_count", count, 8);
        drive(1, 6'd9, 1, 0);
        #1 chk("full_refuse", irq_ack, 0);
        edge_sample();
        chk("full_pop_count", count, 7);
        chk("full_pop_flag", full, 0);
        drive(1, 6'd9, 0, 0);
        #1 chk("full_retry_ack", irq_ack, 1);
        edge_sample();
        chk("full_retry_count", count, 8);
        for (int i = 0; i < 8; i++) begin
            drive(0, 6'd0, 1, 0);
            #1 chk("full_drain_head", cpu_num, (i < 7) ? (11 + i) : 9);
            edge_sample();
        end
        chk("full_drain_empty", empty, 1);

        // push and pop of the same number in one cycle
        drive(1, 6'd5, 0, 0);
        edge_sample();
        drive(1, 6'd5, 1, 0);
        #1 chk("same_ack", irq_ack, 1);
        edge_sample();
        chk("same_count", count, 1);
        chk("same_head", cpu_num, 5);
        chk("same_coal", coal, 0);
        chk("same_pending", dut.r_pending[5], 1);
        drive(0, 6'd0, 1, 0);
        edge_sample();
        chk("same_drain_empty", empty, 1);

        // pointer wrap with steady occupancy of three
        for (int i = 0; i < 3; i++) begin
            drive(1, 6'(20 + i), 0, 0);
            edge_sample();
        end
        for (int i = 0; i < 20; i++) begin
            drive(1, 6'(23 + i), 1, 0);
            #1 chk("wrap_head", cpu_num, 20 + i);
            edge_sample();
            chk("wrap_count", count, 3);
        end

        // flush mid-stream overrides push and pop
        drive(1, 6'd50, 1, 1);
        #1 chk("flush_ack", irq_ack, 0);
        edge_sample();
        chk("flush_count", count, 0);
        chk("flush_empty2", empty, 1);

        // asynchronous reset in the middle of a push
        drive(1, 6'd7, 0, 0);
        edge_sample();
        drive(1, 6'd8, 0, 0);
        #2 rst = 1'b1;
        #1;
        chk("arst_count", count, 0);
        chk("arst_empty", empty, 1);
        chk("arst_full", full, 0);
        chk("arst_cpu_valid", cpu_valid, 0);
        chk("arst_cpu_num", cpu_num, 0);
        chk("arst_ack", irq_ack, 0);
        drive(0, 6'd0, 0, 0);
        rst = 1'b0;
        edge_sample();
        chk("post_rst_empty", empty, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
